// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing constants for the architectural register file.
package regfile_pkg;
  localparam int ROB_SIZE = 16;
  localparam int ROB_WIDTH = $clog2(ROB_SIZE);
  localparam int REG_NUM = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: resolves one source operand to a value or a pending ROB tag.
module regfile_rdport
  import regfile_pkg::*;
(
  input  logic [4:0]           rs,
  input  logic [31:0]          reg_val,
  input  logic                 reg_busy,
  input  logic [ROB_WIDTH-1:0] reg_tag,
  input  logic                 commit_valid,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [31:0]          commit_val,
  input  logic                 search_ready,
  input  logic [31:0]          search_val,
  output logic [31:0]          val,
  output logic                 has_dep,
  output logic [ROB_WIDTH-1:0] dep
);
  logic hit;
  assign hit = commit_valid && commit_rob_id == reg_tag;
  // val is a don't-care whenever has_dep is set, so the last arm needs no guard
  always_comb begin
    val = rs == ZERO_REG ? '0 : !reg_busy ? reg_val : hit ? commit_val : search_val;
    has_dep = rs != ZERO_REG && reg_busy && !hit && !search_ready;
    dep = reg_tag;
  end
endmodule

// File: rtl/regfile.sv
// regfile: architectural registers with rename tags, ROB commit and operand lookup.
module regfile
  import regfile_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [ROB_WIDTH-1:0] issue_rob_id,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic [31:0]          val1,
  output logic [31:0]          val2,
  output logic                 has_dep1,
  output logic                 has_dep2,
  output logic [ROB_WIDTH-1:0] dep1,
  output logic [ROB_WIDTH-1:0] dep2,
  output logic [ROB_WIDTH-1:0] search_rob_id_1,
  output logic [ROB_WIDTH-1:0] search_rob_id_2,
  input  logic                 search_ready_1,
  input  logic                 search_ready_2,
  input  logic [31:0]          search_val_1,
  input  logic [31:0]          search_val_2,
  input  logic                 commit_valid,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [4:0]           commit_reg_id,
  input  logic [31:0]          commit_val
);
  logic [31:0]          regs [REG_NUM];
  logic [ROB_WIDTH-1:0] tag  [REG_NUM];
  logic [REG_NUM-1:0]   busy;
  assign search_rob_id_1 = tag[rs1];
  assign search_rob_id_2 = tag[rs2];
  // Later assignments win: issue overrides commit's busy release, clear overrides both
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
        tag[i] <= '0;
      end
      busy <= '0;
    end else if (rdy_in) begin
      if (commit_valid && commit_reg_id != ZERO_REG) begin
        regs[commit_reg_id] <= commit_val;
        if (busy[commit_reg_id] && tag[commit_reg_id] == commit_rob_id) busy[commit_reg_id] <= 1'b0;
      end
      if (clear) busy <= '0;
      else if (issue_valid && issue_rd != ZERO_REG) begin
        busy[issue_rd] <= 1'b1;
        tag[issue_rd] <= issue_rob_id;
      end
    end
  end
  regfile_rdport u_rd1 (
    .rs(rs1), .reg_val(regs[rs1]), .reg_busy(busy[rs1]), .reg_tag(tag[rs1]),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_val(commit_val),
    .search_ready(search_ready_1), .search_val(search_val_1),
    .val(val1), .has_dep(has_dep1), .dep(dep1)
  );
  regfile_rdport u_rd2 (
    .rs(rs2), .reg_val(regs[rs2]), .reg_busy(busy[rs2]), .reg_tag(tag[rs2]),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_val(commit_val),
    .search_ready(search_ready_2), .search_val(search_val_2),
    .val(val2), .has_dep(has_dep2), .dep(dep2)
  );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scenarios plus randomized traffic against a rename-table model.
module tb_regfile;
  import regfile_pkg::*;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear, issue_valid, commit_valid;
  logic [4:0] issue_rd, rs1, rs2, commit_reg_id;
  logic [ROB_WIDTH-1:0] issue_rob_id, commit_rob_id;
  logic search_ready_1, search_ready_2;
  logic [31:0] search_val_1, search_val_2, commit_val;
  logic [31:0] val1, val2;
  logic has_dep1, has_dep2;
  logic [ROB_WIDTH-1:0] dep1, dep2, search_rob_id_1, search_rob_id_2;
  int tests = 0;
  int fails = 0;
  logic [31:0] m_val [32];
  bit m_pending [32];
  int m_writer [32];

  always #5 clk_in = ~clk_in;

  regfile dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .rs1(rs1), .rs2(rs2), .val1(val1), .val2(val2),
    .has_dep1(has_dep1), .has_dep2(has_dep2), .dep1(dep1), .dep2(dep2),
    .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
    .search_ready_1(search_ready_1), .search_ready_2(search_ready_2),
    .search_val_1(search_val_1), .search_val_2(search_val_2),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val)
  );

  // Operand as the spec describes it: architectural value, same-cycle commit, ROB lookup, or wait
  function automatic void model_read(input logic [4:0] rs, input logic sr, input logic [31:0] sv,
                                     output logic [31:0] v, output logic hd, output logic [ROB_WIDTH-1:0] d);
    int r = int'(rs);
    d = ROB_WIDTH'(m_writer[r]);
    hd = 1'b0;
    v = 32'h0;
    if (r == 0) v = 32'h0;
    else if (!m_pending[r]) v = m_val[r];
    else if (commit_valid && int'(commit_rob_id) == m_writer[r]) v = commit_val;
    else if (sr) v = sv;
    else hd = 1'b1;
  endfunction

  task automatic idle();
    rdy_in = 1'b1; clear = 1'b0; issue_valid = 1'b0; commit_valid = 1'b0;
    search_ready_1 = 1'b0; search_ready_2 = 1'b0;
  endtask

  // Advance one clock and move the model by the same inputs
  task automatic step();
    @(posedge clk_in);
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_pending[i] = 0; m_writer[i] = 0; end
    end else if (rdy_in) begin
      if (commit_valid && commit_reg_id != 0) begin
        m_val[commit_reg_id] = commit_val;
        if (m_pending[commit_reg_id] && m_writer[commit_reg_id] == int'(commit_rob_id)) m_pending[commit_reg_id] = 0;
      end
      if (clear) for (int i = 0; i < 32; i++) m_pending[i] = 0;
      else if (issue_valid && issue_rd != 0) begin
        m_pending[issue_rd] = 1;
        m_writer[issue_rd] = int'(issue_rob_id);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_in = 1'b1; rs1 = 5'd5; rs2 = 5'd0;
    issue_rd = 0; issue_rob_id = 0; commit_reg_id = 0; commit_rob_id = 0; commit_val = 0;
    search_val_1 = 0; search_val_2 = 0;
    step(); step();
    rst_in = 1'b0; #2;
    tests++; if (val1 !== 32'h0) begin fails++; $display("FAIL reset_val1 got %h want 0", val1); end
    tests++; if (val2 !== 32'h0) begin fails++; $display("FAIL reset_val2 got %h want 0", val2); end
    tests++; if (has_dep1 !== 1'b0) begin fails++; $display("FAIL reset_dep1 got %b want 0", has_dep1); end
    tests++; if (has_dep2 !== 1'b0) begin fails++; $display("FAIL reset_dep2 got %b want 0", has_dep2); end
  endtask

  task automatic test_dependency();
    issue_valid = 1; issue_rd = 3; issue_rob_id = 2; step();
    idle(); rs1 = 3; #2;
    tests++; if (has_dep1 !== 1'b1) begin fails++; $display("FAIL dep_pending got %b want 1", has_dep1); end
    tests++; if (dep1 !== 4'd2) begin fails++; $display("FAIL dep_tag got %0d want 2", dep1); end
    tests++; if (search_rob_id_1 !== 4'd2) begin fails++; $display("FAIL dep_search got %0d want 2", search_rob_id_1); end
    search_ready_1 = 1; search_val_1 = 32'h55; #2;
    tests++; if (has_dep1 !== 1'b0 || val1 !== 32'h55) begin fails++; $display("FAIL dep_search_hit got %b/%h want 0/00000055", has_dep1, val1); end
  endtask

  task automatic test_commit_bypass();
    idle(); rs1 = 3;
    commit_valid = 1; commit_rob_id = 2; commit_reg_id = 3; commit_val = 32'hDEAD; #2;
    tests++; if (has_dep1 !== 1'b0 || val1 !== 32'hDEAD) begin fails++; $display("FAIL bypass got %b/%h want 0/0000dead", has_dep1, val1); end
    step(); idle(); #2;
    tests++; if (has_dep1 !== 1'b0 || val1 !== 32'hDEAD) begin fails++; $display("FAIL after_commit got %b/%h want 0/0000dead", has_dep1, val1); end
  endtask

  task automatic test_newer_writer();
    idle(); rs1 = 4;
    issue_valid = 1; issue_rd = 4; issue_rob_id = 1; step();
    issue_rob_id = 6; step();
    idle(); commit_valid = 1; commit_rob_id = 1; commit_reg_id = 4; commit_val = 7; step();
    idle(); #2;
    tests++; if (has_dep1 !== 1'b1 || dep1 !== 4'd6) begin fails++; $display("FAIL stale_commit got %b/%0d want 1/6", has_dep1, dep1); end
    commit_valid = 1; commit_rob_id = 6; commit_val = 9; step();
    idle(); #2;
    tests++; if (has_dep1 !== 1'b0 || val1 !== 32'd9) begin fails++; $display("FAIL newest_commit got %b/%h want 0/00000009", has_dep1, val1); end
  endtask

  task automatic test_same_cycle();
    idle(); rs1 = 8;
    issue_valid = 1; issue_rd = 8; issue_rob_id = 3;
    commit_valid = 1; commit_reg_id = 8; commit_rob_id = 0; commit_val = 32'hABCD; step();
    idle(); #2;
    tests++; if (has_dep1 !== 1'b1 || dep1 !== 4'd3) begin fails++; $display("FAIL issue_wins got %b/%0d want 1/3", has_dep1, dep1); end
    clear = 1; step(); idle(); #2;
    tests++; if (has_dep1 !== 1'b0 || val1 !== 32'hABCD) begin fails++; $display("FAIL commit_kept got %b/%h want 0/0000abcd", has_dep1, val1); end
  endtask

  task automatic test_clear();
    idle();
    issue_valid = 1; issue_rd = 10; issue_rob_id = 4; step();
    issue_rd = 11; issue_rob_id = 5; step();
    idle(); clear = 1; commit_valid = 1; commit_reg_id = 10; commit_rob_id = 9; commit_val = 32'h11;
    issue_valid = 1; issue_rd = 12; issue_rob_id = 7; step();
    idle(); rs1 = 10; rs2 = 11; #2;
    tests++; if (has_dep1 !== 1'b0 || val1 !== 32'h11) begin fails++; $display("FAIL clear_commit got %b/%h want 0/00000011", has_dep1, val1); end
    tests++; if (has_dep2 !== 1'b0 || val2 !== 32'h0) begin fails++; $display("FAIL clear_r11 got %b/%h want 0/00000000", has_dep2, val2); end
    rs1 = 12; #2;
    tests++; if (has_dep1 !== 1'b0) begin fails++; $display("FAIL clear_drop_issue got %b want 0", has_dep1); end
    commit_valid = 1; commit_reg_id = 0; commit_rob_id = 0; commit_val = 1; step();
    idle(); rs1 = 0; #2;
    tests++; if (val1 !== 32'h0 || has_dep1 !== 1'b0) begin fails++; $display("FAIL x0 got %b/%h want 0/00000000", has_dep1, val1); end
    rdy_in = 0; issue_valid = 1; issue_rd = 13; issue_rob_id = 2; step();
    idle(); rs1 = 13; #2;
    tests++; if (has_dep1 !== 1'b0) begin fails++; $display("FAIL rdy_hold got %b want 0", has_dep1); end
  endtask

  task automatic test_random();
    logic [31:0] ev1, ev2;
    logic eh1, eh2;
    logic [ROB_WIDTH-1:0] ed1, ed2;
    for (int n = 0; n < 400; n++) begin
      rdy_in = ($urandom % 8) != 0;
      clear = ($urandom % 16) == 0;
      issue_valid = $urandom % 2; issue_rd = 5'($urandom % 8); issue_rob_id = ROB_WIDTH'($urandom);
      commit_valid = $urandom % 2; commit_reg_id = 5'($urandom % 8);
      commit_rob_id = ROB_WIDTH'($urandom); commit_val = $urandom;
      rs1 = 5'($urandom % 8); rs2 = 5'($urandom % 8);
      search_ready_1 = ($urandom % 4) == 0; search_ready_2 = ($urandom % 4) == 0;
      search_val_1 = $urandom; search_val_2 = $urandom;
      #2;
      model_read(rs1, search_ready_1, search_val_1, ev1, eh1, ed1);
      model_read(rs2, search_ready_2, search_val_2, ev2, eh2, ed2);
      tests++; if (has_dep1 !== eh1 || (!eh1 && val1 !== ev1) || (eh1 && dep1 !== ed1) || search_rob_id_1 !== ed1) begin
        fails++; $display("FAIL rand_port1 n=%0d got %b/%h/%0d/%0d want %b/%h/%0d", n, has_dep1, val1, dep1, search_rob_id_1, eh1, ev1, ed1);
      end
      tests++; if (has_dep2 !== eh2 || (!eh2 && val2 !== ev2) || (eh2 && dep2 !== ed2) || search_rob_id_2 !== ed2) begin
        fails++; $display("FAIL rand_port2 n=%0d got %b/%h/%0d/%0d want %b/%h/%0d", n, has_dep2, val2, dep2, search_rob_id_2, eh2, ev2, ed2);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_dependency();
    test_commit_bypass();
    test_newer_writer();
    test_same_cycle();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Architectural register file with rename tags for the out-of-order core.
- Consumer end of the ROB commit and search interfaces: receives committed (rob_id, reg, value), and drives search rob ids to the ROB to resolve in-flight operands.
- At issue it gives the decoder/RS each source operand either as a value or as a ROB dependency tag, then renames the destination register to the issuing ROB entry.

Parameters:
- ROB_WIDTH, `ROB_WIDTH from params.v: ROB index width.
- ROB_SIZE, `ROB_SIZE from params.v: ROB entry count; tag range is 0..ROB_SIZE-1.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; synchronous, active-high.
- rdy_in  in  1  pause when low; all state holds.
- clear  in  1  pipeline flush (mispredict).
- issue_valid  in  1  instruction issues this cycle.
- issue_rd  in  5  destination register.
- issue_rob_id  in  ROB_WIDTH  ROB entry allocated (ROB empty_rob_id).
- rs1, rs2  in  5 each  source register indices.
- val1, val2  out  32 each  operand value; meaningful when matching has_dep is 0.
- has_dep1, has_dep2  out  1 each  operand still pending.
- dep1, dep2  out  ROB_WIDTH each  pending producer rob id.
- search_rob_id_1, search_rob_id_2  out  ROB_WIDTH each  to ROB: tag[rs1], tag[rs2].
- search_ready_1, search_ready_2  in  1 each  ROB entry already written back.
- search_val_1, search_val_2  in  32 each  ROB entry value.
- commit_valid  in  1  commit this cycle.
- commit_rob_id  in  ROB_WIDTH  committing entry.
- commit_reg_id  in  5  destination of committing entry.
- commit_val  in  32  committed value.

Behaviour:
- State per register i in 0..31: regs[i] (32 bits), busy[i] (1 bit), tag[i] (ROB_WIDTH bits).
- Reset (rst_in=1 at clock edge): every regs=0, busy=0, tag=0. Outputs are combinational, so the cycle after reset gives val=0 and has_dep=0 for any rs.
- Read path is combinational and identical per port. Priority:
  - rs==0: val=0, has_dep=0.
  - else if !busy[rs]: val=regs[rs], has_dep=0.
  - else if commit_valid and commit_rob_id==tag[rs]: val=commit_val, has_dep=0 (same-cycle commit bypass).
  - else if search_ready: val=search_val, has_dep=0.
  - else: has_dep=1, dep=tag[rs], val=don't-care.
  - search_rob_id_k = tag[rs_k] at all times.
- Reads observe pre-issue state. An instruction with rs==rd never depends on itself.
- Sequential update at posedge, only when rdy_in=1 and rst_in=0:
  - Commit: if commit_valid and commit_reg_id!=0, regs[commit_reg_id]<=commit_val. If busy[commit_reg_id] and tag[commit_reg_id]==commit_rob_id, busy<=0. A tag mismatch means a newer writer exists; the value is written and busy is kept.
  - Issue: if issue_valid, issue_rd!=0 and !clear, busy[issue_rd]<=1 and tag[issue_rd]<=issue_rob_id. When issue and commit hit the same register in one cycle, issue wins busy/tag and commit still writes regs.
  - Clear: all busy<=0, regs retained. A same-cycle commit still updates regs, since commit is older than the flush. A same-cycle issue is dropped.
- x0: never written, never busy. Issue/commit with rd=0 has no effect.
- rdy_in=0: no state change. Reads still reflect current state.
- Tag wrap: tags are raw ROB indices. Reuse is safe because the ROB never reallocates an entry before committing it.

Decomposition:
- params.v (shared): ROB_WIDTH, ROB_SIZE macros. Add REG_NUM=32 and a ZERO_REG=0 constant.
- One natural sub-module: regfile_rdport, the combinational operand-resolve priority logic. Instantiate it twice (rs1, rs2). State stays in regfile.

Test Plan:
- Reset, then rs1=5, rs2=0 -> val1=0, val2=0, has_dep1=has_dep2=0.
- Issue rd=3, rob_id=2; next cycle rs1=3, search_ready_1=0 -> has_dep1=1, dep1=2, search_rob_id_1=2. Drive search_ready_1=1, search_val_1=0x55 -> has_dep1=0, val1=0x55.
- Commit rob_id=2, reg=3, val=0xDEAD with rs1=3 in the same cycle -> val1=0xDEAD, has_dep1=0 combinationally. Next cycle busy[3]=0, val1=0xDEAD.
- Issue rd=4 rob=1, then issue rd=4 rob=6, then commit rob=1 reg=4 val=7 -> regs[4]=7, has_dep stays 1 with dep=6. Commit rob=6 val=9 -> val=9, has_dep=0.
- Same cycle: issue rd=8 rob=3 and commit reg=8 rob=0 (tag matched) -> busy[8]=1, tag[8]=3, regs[8]=commit_val.
- Issue rd=10 rob=4, issue rd=11 rob=5, then clear with commit reg=10 val=0x11 and issue rd=12 -> all has_dep=0, regs[10]=0x11, regs[11] unchanged, rd=12 not busy. Also: commit reg=0 val=1 -> x0 still reads 0. rdy_in=0 with issue -> no busy change.
